// File: rtl/stall_ctrl.sv
// ============================================================================
// stall_ctrl : pipeline hazard, stall and flush control with memory watchdog
// Rev 1.0
// ============================================================================
`default_nettype none

module stall_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read_i,
  input  logic [4:0]  id_reg1_addr_i,
  input  logic        id_reg2_read_i,
  input  logic [4:0]  id_reg2_addr_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        if_stallreq_i,
  input  logic        mem_stallreq_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cnt_o,
  output logic        timeout_o
);

  localparam int                c_WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_PEND  = 2'd2
  } state_t;

  state_t              r_state;
  logic [31:0]         r_pend_pc;
  logic [31:0]         r_stall_cnt;
  logic [c_WD_W-1:0]   r_wd_cnt;
  logic                r_timeout;
  logic                w_load_use;

  assign w_load_use = ex_load_i && (ex_wd_i != 5'd0) &&
                      ((id_reg1_read_i && (id_reg1_addr_i == ex_wd_i)) ||
                       (id_reg2_read_i && (id_reg2_addr_i == ex_wd_i)));

  // A fresh branch pulse in the release cycle supersedes the pending target.
  always_comb begin
    stall_o  = 6'b000000;
    flush_o  = 1'b0;
    new_pc_o = 32'd0;
    if (rst) begin
      if (mem_stallreq_i) begin
        stall_o = 6'b011111;
      end else if (branch_flag_i) begin
        flush_o  = 1'b1;
        new_pc_o = branch_target_i;
      end else if (r_state == BR_PEND) begin
        flush_o  = 1'b1;
        new_pc_o = r_pend_pc;
      end else if (w_load_use) begin
        stall_o = 6'b000111;
      end else if (if_stallreq_i) begin
        stall_o = 6'b000011;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_pend_pc   <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (mem_stallreq_i) begin
        if (branch_flag_i) begin
          r_state   <= BR_PEND;
          r_pend_pc <= branch_target_i;
        end else if (r_state != BR_PEND) begin
          r_state <= MEM_WAIT;
        end
      end else begin
        r_state <= RUN;
      end

      if ((stall_o != 6'b000000) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end

      if (mem_stallreq_i) begin
        if (r_wd_cnt != c_WD_MAX) begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
        if (r_wd_cnt >= c_WD_MAX - 1'b1) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign timeout_o   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_stall_ctrl.sv
// ============================================================================
// tb_stall_ctrl : directed self-checking bench for stall_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_reg1_read_i;
  logic [4:0]  id_reg1_addr_i;
  logic        id_reg2_read_i;
  logic [4:0]  id_reg2_addr_i;
  logic        ex_load_i;
  logic [4:0]  ex_wd_i;
  logic        if_stallreq_i;
  logic        mem_stallreq_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] stall_cnt_o;
  logic        timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  stall_ctrl #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_read_i  (id_reg1_read_i),
    .id_reg1_addr_i  (id_reg1_addr_i),
    .id_reg2_read_i  (id_reg2_read_i),
    .id_reg2_addr_i  (id_reg2_addr_i),
    .ex_load_i       (ex_load_i),
    .ex_wd_i         (ex_wd_i),
    .if_stallreq_i   (if_stallreq_i),
    .mem_stallreq_i  (mem_stallreq_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o),
    .stall_cnt_o     (stall_cnt_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag, input logic [5:0] st, input logic fl,
                            input logic [31:0] pc);
    check({tag, "_stall"}, {26'd0, stall_o}, {26'd0, st});
    check({tag, "_flush"}, {31'd0, flush_o}, {31'd0, fl});
    check({tag, "_newpc"}, new_pc_o, pc);
  endtask

  task automatic idle_inputs();
    id_reg1_read_i  = 1'b0;
    id_reg1_addr_i  = 5'd0;
    id_reg2_read_i  = 1'b0;
    id_reg2_addr_i  = 5'd0;
    ex_load_i       = 1'b0;
    ex_wd_i         = 5'd0;
    if_stallreq_i   = 1'b0;
    mem_stallreq_i  = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: outputs held at zero even with a memory stall requested
    rst = 1'b0;
    idle_inputs();
    mem_stallreq_i = 1'b1;
    #12;
    check_comb("rst", 6'b000000, 1'b0, 32'd0);
    check("rst_cnt", stall_cnt_o, 32'd0);
    check("rst_to", {31'd0, timeout_o}, 32'd0);
    mem_stallreq_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_comb("idle", 6'b000000, 1'b0, 32'd0);

    // Load-use on rs2, then bubble clears it
    ex_load_i = 1'b1; ex_wd_i = 5'd5; id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd5;
    #1 check_comb("lu2", 6'b000111, 1'b0, 32'd0);
    tick();
    check("lu2_cnt", stall_cnt_o, 32'd1);
    ex_load_i = 1'b0;
    #1 check_comb("lu2_bubble", 6'b000000, 1'b0, 32'd0);

    // x0 destination never hazards
    ex_load_i = 1'b1; ex_wd_i = 5'd0; id_reg2_addr_i = 5'd0;
    #1 check_comb("lu_x0", 6'b000000, 1'b0, 32'd0);
    tick();
    check("lu_x0_cnt", stall_cnt_o, 32'd1);

    // Load-use on rs1; no hazard when rs1 not read
    idle_inputs();
    ex_load_i = 1'b1; ex_wd_i = 5'd7; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd7;
    #1 check_comb("lu1", 6'b000111, 1'b0, 32'd0);
    tick();
    check("lu1_cnt", stall_cnt_o, 32'd2);
    id_reg1_read_i = 1'b0;
    #1 check_comb("lu1_noread", 6'b000000, 1'b0, 32'd0);

    // Fetch stall alone
    idle_inputs();
    if_stallreq_i = 1'b1;
    #1 check_comb("ifst", 6'b000011, 1'b0, 32'd0);
    tick();
    check("ifst_cnt", stall_cnt_o, 32'd3);

    // Branch beats load-use and fetch stall
    ex_load_i = 1'b1; ex_wd_i = 5'd9; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd9;
    branch_flag_i = 1'b1; branch_target_i = 32'h40;
    #1 check_comb("br_prio", 6'b000000, 1'b1, 32'h40);
    tick();
    check("br_prio_cnt", stall_cnt_o, 32'd3);

    // Branch during memory stall is held until memory releases
    idle_inputs();
    mem_stallreq_i = 1'b1;
    #1 check_comb("mw1", 6'b011111, 1'b0, 32'd0);
    tick();
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    #1 check_comb("mw2", 6'b011111, 1'b0, 32'd0);
    tick();
    branch_flag_i = 1'b0; branch_target_i = 32'd0;
    #1 check_comb("mw3", 6'b011111, 1'b0, 32'd0);
    tick();
    check("mw_cnt", stall_cnt_o, 32'd6);
    mem_stallreq_i = 1'b0;
    #1 check_comb("mw_release", 6'b000000, 1'b1, 32'h100);
    tick();
    check_comb("mw_run", 6'b000000, 1'b0, 32'd0);
    check("mw_to", {31'd0, timeout_o}, 32'd0);

    // Watchdog trips on the 4th consecutive stall edge and sticks
    mem_stallreq_i = 1'b1;
    tick(); tick(); tick();
    check("wd_3", {31'd0, timeout_o}, 32'd0);
    tick();
    check("wd_4", {31'd0, timeout_o}, 32'd1);
    check("wd_cnt", stall_cnt_o, 32'd10);
    mem_stallreq_i = 1'b0;
    #1 check_comb("wd_release", 6'b000000, 1'b0, 32'd0);
    tick();
    check("wd_sticky", {31'd0, timeout_o}, 32'd1);

    // Later pulse while pending overwrites the target
    mem_stallreq_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h300;
    tick();
    branch_target_i = 32'h304;
    tick();
    idle_inputs();
    #1 check_comb("br_overwrite", 6'b000000, 1'b1, 32'h304);
    tick();

    // Reset mid-pending discards the branch
    mem_stallreq_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h200;
    tick();
    branch_flag_i = 1'b0; branch_target_i = 32'd0;
    #2 rst = 1'b0;
    #1 check_comb("rst_pend", 6'b000000, 1'b0, 32'd0);
    check("rst_pend_cnt", stall_cnt_o, 32'd0);
    check("rst_pend_to", {31'd0, timeout_o}, 32'd0);
    mem_stallreq_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_comb("rst_noflush", 6'b000000, 1'b0, 32'd0);
    tick();
    check_comb("rst_noflush2", 6'b000000, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024: consecutive memory-stall cycles that trip the watchdog.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 id_reg1_read_i  in  1  ID reads rs1 from the register file.
REQ-005 id_reg1_addr_i  in  5  ID rs1 address.
REQ-006 id_reg2_read_i  in  1  ID reads rs2 from the register file.
REQ-007 id_reg2_addr_i  in  5  ID rs2 address.
REQ-008 ex_load_i  in  1  instruction in EX is a load.
REQ-009 ex_wd_i  in  5  EX destination register.
REQ-010 if_stallreq_i  in  1  instruction fetch not ready.
REQ-011 mem_stallreq_i  in  1  data memory not ready; level, held until the access completes.
REQ-012 branch_flag_i  in  1  one-cycle pulse from EX: taken branch/jump.
REQ-013 branch_target_i  in  32  target PC, valid with branch_flag_i.
REQ-014 stall_o  out  6  freeze vector: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
REQ-015 flush_o  out  1  squash IF/ID and ID/EX contents, one cycle.
REQ-016 new_pc_o  out  32  redirect PC, valid when flush_o=1.
REQ-017 stall_cnt_o  out  32  total cycles with stall_o != 0.
REQ-018 timeout_o  out  1  sticky watchdog flag.

Function
REQ-019 States: RUN, MEM_WAIT, BR_PEND; state, pending target, stall counters and timeout flag are the only registers; stall_o, flush_o, new_pc_o are combinational from state and inputs.
REQ-020 Load-use hazard = ex_load_i & ((id_reg1_read_i & id_reg1_addr_i==ex_wd_i) | (id_reg2_read_i & id_reg2_addr_i==ex_wd_i)) & ex_wd_i != 0.
REQ-021 Per-cycle priority: mem_stallreq_i > flush (branch_flag_i or BR_PEND release) > load-use > if_stallreq_i.
REQ-022 mem_stallreq_i=1: stall_o=6'b011111, flush_o=0; state -> MEM_WAIT (or stays BR_PEND).
REQ-023 branch_flag_i=1 with mem_stallreq_i=1: latch branch_target_i into pending register, state -> BR_PEND; a later pulse while in BR_PEND overwrites the target.
REQ-024 BR_PEND with mem_stallreq_i=0: flush_o=1, new_pc_o=pending target, stall_o=0 for that cycle; state -> RUN next edge.
REQ-025 RUN/MEM_WAIT with mem_stallreq_i=0 and branch_flag_i=1: flush_o=1, new_pc_o=branch_target_i, stall_o=0 in the same cycle; load-use and if_stallreq_i ignored that cycle.
REQ-026 Load-use (no higher-priority event): stall_o=6'b000111 for that cycle; EX receives a bubble, so hazard self-clears next cycle; exactly one bubble per load.
REQ-027 if_stallreq_i alone: stall_o=6'b000011.
REQ-028 Otherwise stall_o=0, flush_o=0; new_pc_o=0 whenever flush_o=0.
REQ-029 MEM_WAIT -> RUN on first cycle mem_stallreq_i=0 with no pending branch.
REQ-030 Watchdog counter increments each cycle mem_stallreq_i=1, clears when it is 0; reaching TIMEOUT sets timeout_o, which stays 1 until reset; counter saturates at TIMEOUT.
REQ-031 stall_cnt_o increments each cycle stall_o != 0; saturates at 32'hFFFFFFFF (no wrap).

Reset
REQ-032 rst=0 asynchronously forces: state RUN, pending target 0, stall_cnt_o 0, watchdog 0, timeout_o 0, and stall_o=0, flush_o=0, new_pc_o=0 while asserted.
REQ-033 Reset mid-MEM_WAIT or BR_PEND discards the pending branch; after release no flush is emitted.

Verification
REQ-034 ex_load_i=1, ex_wd_i=5, id_reg2_read_i=1, id_reg2_addr_i=5 -> stall_o=000111 one cycle, stall_cnt_o 0->1; same with ex_wd_i=0 -> stall_o=0.
REQ-035 mem_stallreq_i=1 for 3 cycles, branch_flag_i pulse (target 32'h100) in cycle 2 -> stall_o=011111 x3, then flush_o=1, new_pc_o=32'h100, stall_o=0 one cycle, then RUN.
REQ-036 branch_flag_i (target 32'h40) coincident with load-use and if_stallreq_i -> flush_o=1, new_pc_o=32'h40, stall_o=0.
REQ-037 TIMEOUT=4, mem_stallreq_i=1 for 4 cycles -> timeout_o=1 after 4th edge, remains 1 after mem_stallreq_i drops.
REQ-038 rst=0 asserted in BR_PEND between edges -> all outputs 0 immediately; after release with mem_stallreq_i=0 -> no flush_o.
